bitline_serial_alu: RTL and testbench

Bit-serial, multi-lane arithmetic/logic unit sitting under the compute-SRAM column periphery. Each lane consumes one column's bit-line pair per cycle (BL = A AND B, BLB = NOR(A,B) from dual-wordline activation), keeps its own carry latch, and writes one result bit per cycle back to the array. The block sequences a full WORD_BITS-wide transposed operation: row reads, carry chaining, and the final carry-out row. It generalises the fixed 4-bit ripple slice to LANES parallel columns of arbitrary word length, with predication and logic modes.

---
 rtl/bitline_alu_pkg.sv | 28 ++
 rtl/bitline_alu_lane_fa.sv | 16 +
 rtl/bitline_serial_alu.sv | 136 +++++++++++++
 tb/tb_bitline_serial_alu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitline_alu_pkg.sv
// Shared types for the bit-serial bit-line ALU.
// Op codes, FSM states and small op-decode helpers.
package bitline_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_ADD_CI = 3'd1,
    OP_AND    = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_CARRY
  } state_e;

  function automatic logic op_is_add(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADD_CI);
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/bitline_alu_lane_fa.sv
// One-lane full-adder cell fed by a bit-line pair.
// BL = A&B and BLB = ~(A|B), so ~(BL|BLB) recovers A^B.
module bitline_lane_fa (
  input  logic bl,
  input  logic blb,
  input  logic c,
  output logic x,
  output logic sum,
  output logic c_next
);

  assign x      = ~(bl | blb);
  assign sum    = x ^ c;
  assign c_next = bl | (x & c);

endmodule

// File: rtl/bitline_serial_alu.sv
// Bit-serial multi-lane ALU under the compute-SRAM columns.
// Sequences row reads, per-lane carry chaining and the carry-out row.
module bitline_serial_alu
  import bitline_alu_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int WORD_BITS = 8,
  parameter int IDX_W     = $clog2(WORD_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [LANES-1:0] mask,
  output logic             busy,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [LANES-1:0] bl,
  input  logic [LANES-1:0] blb,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [LANES-1:0] wr_data,
  output logic [LANES-1:0] wr_mask,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST  = IDX_W'(WORD_BITS - 1);
  localparam logic [IDX_W-1:0] C_ROW = IDX_W'(WORD_BITS);

  state_e           state;
  op_e              op_q;
  logic [LANES-1:0] mask_q;
  logic [LANES-1:0] carry;
  logic             vld;
  logic [IDX_W-1:0] vidx;

  logic [LANES-1:0] x_v;
  logic [LANES-1:0] sum_v;
  logic [LANES-1:0] cn_v;
  logic [LANES-1:0] sel;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bitline_lane_fa u_fa (
      .bl     (bl[l]),
      .blb    (blb[l]),
      .c      (carry[l]),
      .x      (x_v[l]),
      .sum    (sum_v[l]),
      .c_next (cn_v[l])
    );
  end

  always_comb begin
    sel = sum_v;
    unique case (op_q)
      OP_AND:  sel = bl;
      OP_NOR:  sel = blb;
      OP_XOR:  sel = x_v;
      default: sel = sum_v;
    endcase
  end

  // vld/vidx track which row's bit-lines are on the inputs this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      mask_q  <= '0;
      carry   <= '0;
      vld     <= 1'b0;
      vidx    <= '0;
      busy    <= 1'b0;
      rd_en   <= 1'b0;
      rd_idx  <= '0;
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
      wr_mask <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      vld   <= rd_en;
      vidx  <= rd_idx;
      if (done) busy <= 1'b0;
      if (vld) begin
        wr_en   <= 1'b1;
        wr_idx  <= vidx;
        wr_data <= sel;
        wr_mask <= mask_q;
        if (op_is_add(op_q)) carry <= cn_v & mask_q;
      end
      unique case (state)
        S_IDLE: begin
          if (start && !busy && op_legal(op)) begin
            state  <= S_READ;
            busy   <= 1'b1;
            rd_en  <= 1'b1;
            rd_idx <= '0;
            mask_q <= mask;
            op_q   <= op_e'(op);
            carry  <= (op == OP_ADD_CI) ? mask : '0;
          end
        end
        S_READ: begin
          if (rd_idx == LAST) begin
            rd_en  <= 1'b0;
            rd_idx <= '0;
            state  <= S_DRAIN;
          end else begin
            rd_idx <= rd_idx + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          if (vld && vidx == LAST) begin
            if (op_is_add(op_q)) begin
              state <= S_CARRY;
            end else begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        S_CARRY: begin
          wr_en   <= 1'b1;
          wr_idx  <= C_ROW;
          wr_data <= carry;
          wr_mask <= mask_q;
          done    <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitline_serial_alu.sv
// Scoreboard bench for bitline_serial_alu.
// Array model drives bit-lines; expected rows come from word arithmetic.
module tb_bitline_serial_alu;

  localparam int L  = 8;
  localparam int W  = 8;
  localparam int IW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [L-1:0]  mask;
  logic          busy;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic [L-1:0]  bl;
  logic [L-1:0]  blb;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [L-1:0]  wr_data;
  logic [L-1:0]  wr_mask;
  logic          done;

  bitline_serial_alu #(
    .LANES     (L),
    .WORD_BITS (W),
    .IDX_W     (IW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .mask    (mask),
    .busy    (busy),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .bl      (bl),
    .blb     (blb),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_mask (wr_mask),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] a [L];
  logic [W-1:0] b [L];

  typedef struct {
    int            at;
    logic [IW-1:0] idx;
    logic [L-1:0]  data;
    logic [L-1:0]  msk;
    bit            last;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Array: a row read with rd_en returns bit-lines one cycle later
  initial begin
    bl  = '0;
    blb = '0;
    forever begin
      logic          r;
      logic [IW-1:0] ix;
      @(negedge clk);
      r  = rd_en;
      ix = rd_idx;
      @(posedge clk);
      #1;
      if (r && ix < IW'(W)) begin
        for (int l = 0; l < L; l++) begin
          bl[l]  = a[l][ix] & b[l][ix];
          blb[l] = ~(a[l][ix] | b[l][ix]);
        end
      end else begin
        bl  = L'($urandom);
        blb = L'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: idx %0d at cycle %0d", wr_idx, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_cycle", cyc, e.at);
        chk("wr_idx", 32'(wr_idx), 32'(e.idx));
        chk("wr_mask", 32'(wr_mask), 32'(e.msk));
        chk("wr_data", 32'(wr_data & e.msk), 32'(e.data & e.msk));
        chk("done", 32'(done), 32'(e.last));
      end
    end else if (!rst && done) begin
      checks++;
      errors++;
      $display("FAIL done_without_write at cycle %0d", cyc);
    end
  end

  task automatic push_expect(input int o, input logic [L-1:0] msk,
                             input int e0);
    logic [W:0] full [L];
    exp_t e;
    bit add;
    add = (o <= 1);
    for (int l = 0; l < L; l++)
      full[l] = {1'b0, a[l]} + {1'b0, b[l]} + ((o == 1) ? 1 : 0);
    for (int i = 0; i <= W; i++) begin
      if (i == W && !add) break;
      e.at   = e0 + i + 2;
      e.idx  = IW'(i);
      e.msk  = msk;
      e.last = add ? (i == W) : (i == W - 1);
      for (int l = 0; l < L; l++) begin
        case (o)
          2:       e.data[l] = a[l][i] & b[l][i];
          3:       e.data[l] = ~(a[l][i] | b[l][i]);
          4:       e.data[l] = a[l][i] ^ b[l][i];
          default: e.data[l] = full[l][i];
        endcase
      end
      q.push_back(e);
    end
  endtask

  task automatic rand_ab();
    for (int l = 0; l < L; l++) begin
      a[l] = W'($urandom);
      b[l] = W'($urandom);
    end
  endtask

  task automatic run(input int o, input logic [L-1:0] msk,
                     input bit poke, input bit do_rst);
    int e0;
    int len;
    start = 1'b1;
    op    = 3'(o);
    mask  = msk;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    mask  = L'($urandom);
    e0    = cyc;
    if (o > 4) begin
      repeat (4) begin
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rd_en", 32'(rd_en), 0);
        @(posedge clk);
        #1;
      end
      return;
    end
    len = (o <= 1) ? W + 3 : W + 2;
    push_expect(o, msk, e0);
    for (int k = 0; k < len; k++) begin
      chk("busy_hi", 32'(busy), 1);
      chk("rd_en_seq", 32'(rd_en), (k < W) ? 1 : 0);
      if (poke && k == 3) begin
        start = 1'b1;
        op    = 3'd0;
      end
      if (poke && k == 4) start = 1'b0;
      if (do_rst && k == 3) begin
        rst = 1'b1;
        #1;
        chk("reset_outs", {4'(busy), 4'(rd_en), 4'(wr_en), 4'(done),
                           4'(rd_idx), 4'(wr_idx), wr_data, wr_mask}, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_busy", 32'(busy), 0);
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("busy_lo", 32'(busy), 0);
    chk("rd_en_lo", 32'(rd_en), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    mask  = '0;
    rand_ab();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {4'(busy), 4'(rd_en), 4'(wr_en), 4'(done),
                        4'(rd_idx), 4'(wr_idx), wr_data, wr_mask}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    rand_ab();
    a[0] = 8'h5A; b[0] = 8'h3C;
    a[1] = 8'hFF; b[1] = 8'h01;
    run(0, 8'hFF, 1'b0, 1'b0);

    for (int l = 0; l < L; l++) begin
      a[l] = 8'h0F;
      b[l] = 8'hFA;
    end
    run(1, 8'hFF, 1'b0, 1'b0);

    rand_ab();
    run(0, 8'hAA, 1'b0, 1'b0);

    for (int l = 0; l < L; l++) begin
      a[l] = 8'hC3;
      b[l] = 8'h5A;
    end
    run(4, 8'hFF, 1'b0, 1'b0);

    run(7, 8'hFF, 1'b0, 1'b0);
    rand_ab();
    run(0, 8'hFF, 1'b1, 1'b0);

    rand_ab();
    run(0, 8'hFF, 1'b0, 1'b1);
    rand_ab();
    run(0, 8'hFF, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rand_ab();
      run($urandom_range(0, 7), L'($urandom), n[2], 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
